// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// T-state encodings and instruction classes.
package cu_pkg;

    localparam int OPC_W    = 5;
    localparam int ALU_OP_W = 5;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011,
                                 OPC_SUB  = 5'b00100,
                                 OPC_AND  = 5'b00101,
                                 OPC_OR   = 5'b00110,
                                 OPC_ADDI = 5'b01100,
                                 OPC_MUL  = 5'b01111,
                                 OPC_BR   = 5'b10010,
                                 OPC_IN   = 5'b10110,
                                 OPC_OUT  = 5'b10111,
                                 OPC_MFHI = 5'b11000,
                                 OPC_MFLO = 5'b11001,
                                 OPC_NOP  = 5'b11010,
                                 OPC_HALT = 5'b11011;

    localparam logic [ALU_OP_W-1:0] ALU_NONE = 5'b00000,
                                    ALU_ADD  = 5'b00011,
                                    ALU_MUL  = 5'b01111;

    typedef enum logic [3:0] {
        S_T0   = 4'h0,
        S_T1   = 4'h1,
        S_T2   = 4'h2,
        S_T3   = 4'h3,
        S_T4   = 4'h4,
        S_T5   = 4'h5,
        S_T6   = 4'h6,
        S_HALT = 4'hE,
        S_RST  = 4'hF
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE = 4'd0,
        CL_ADDI  = 4'd1,
        CL_MUL   = 4'd2,
        CL_MFHI  = 4'd3,
        CL_MFLO  = 4'd4,
        CL_IN    = 4'd5,
        CL_OUT   = 4'd6,
        CL_BR    = 4'd7,
        CL_NOP   = 4'd8,
        CL_HALT  = 4'd9
    } iclass_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode to instruction-class decoder. The br class only exists when
// CU_BRANCH_EN is defined; otherwise opcode 10010 falls through to nop.
module cu_decode
    import cu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic [3:0]       iclass_o
);

    // Map each opcode to the class that selects its execute-phase strobes.
    always_comb begin
        iclass_o = CL_NOP;
        case (opcode_i)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: iclass_o = CL_RTYPE;
            OPC_ADDI:                          iclass_o = CL_ADDI;
            OPC_MUL:                           iclass_o = CL_MUL;
            OPC_MFHI:                          iclass_o = CL_MFHI;
            OPC_MFLO:                          iclass_o = CL_MFLO;
            OPC_IN:                            iclass_o = CL_IN;
            OPC_OUT:                           iclass_o = CL_OUT;
            OPC_HALT:                          iclass_o = CL_HALT;
`ifdef CU_BRANCH_EN
            OPC_BR:                            iclass_o = CL_BR;
`endif
            default:                           iclass_o = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit driving the Datapath strobes.
// Fetch T0-T2, execute T3-T6, HALT until Clear. Optional branch support
// is enabled with the CU_BRANCH_EN macro.
module control_sequencer
    import cu_pkg::*;
(
    input  logic                Clock,
    input  logic                Clear,
    input  logic [31:0]         IR,
    input  logic                Stop,
    input  logic                CON_FF,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhiout,
    output logic                MDRout,
    output logic                HIout,
    output logic                LOout,
    output logic                InPortout,
    output logic                Cout,
    output logic                MARin,
    output logic                Zin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                HIin,
    output logic                LOin,
    output logic                Out_Portin,
    output logic                CONin,
    output logic                IncPC,
    output logic                Read,
    output logic                Write,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic [ALU_OP_W-1:0] ALU_op,
    output logic                Run,
    output logic [3:0]          Present_state
);

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opc_q;
    logic [OPC_W-1:0] opc_cur;
    logic [3:0]       iclass_raw;
    iclass_t          iclass;
    logic             last_state;

    logic unused_ir;
    assign unused_ir = ^IR[26:0];

    // The Datapath IR becomes valid at T3, so T3 decodes the live IR and
    // later execute states use the copy captured on leaving T3.
    assign opc_cur = (state_q == S_T3) ? IR[31:27] : opc_q;

    cu_decode u_decode (
        .opcode_i (opc_cur),
        .iclass_o (iclass_raw)
    );

    assign iclass = iclass_t'(iclass_raw);

    // Flag the final execute state of the current instruction.
    always_comb begin
        last_state = 1'b0;
        case (iclass)
            CL_RTYPE, CL_ADDI: last_state = (state_q == S_T5);
            CL_MUL, CL_BR:     last_state = (state_q == S_T6);
            default:           last_state = (state_q == S_T3);
        endcase
    end

    // Next-state selection; Stop only matters at an instruction boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6: begin
                if (state_q == S_T3 && iclass == CL_HALT) begin
                    state_d = S_HALT;
                end else if (last_state) begin
                    state_d = Stop ? S_HALT : S_T0;
                end else begin
                    case (state_q)
                        S_T3:    state_d = S_T4;
                        S_T4:    state_d = S_T5;
                        default: state_d = S_T6;
                    endcase
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // State register and opcode capture; Clear aborts immediately.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_RST;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_T3) begin
                opc_q <= IR[31:27];
            end
        end
    end

    // Moore strobe decode from the current state and instruction class.
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhiout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; Out_Portin = 1'b0; CONin = 1'b0;
        IncPC = 1'b0; Read = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        ALU_op = ALU_NONE;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (iclass)
                    CL_RTYPE, CL_ADDI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_MUL:  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_OUT:  begin Gra = 1'b1; Rout = 1'b1; Out_Portin = 1'b1; end
`ifdef CU_BRANCH_EN
                    CL_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T4: begin
                case (iclass)
                    CL_RTYPE: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = opc_cur; end
                    CL_ADDI:  begin Cout = 1'b1; Zin = 1'b1; ALU_op = ALU_ADD; end
                    CL_MUL:   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = ALU_MUL; end
`ifdef CU_BRANCH_EN
                    CL_BR:    begin PCout = 1'b1; Yin = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T5: begin
                case (iclass)
                    CL_RTYPE, CL_ADDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MUL:   begin Zlowout = 1'b1; LOin = 1'b1; end
`ifdef CU_BRANCH_EN
                    CL_BR:    begin Cout = 1'b1; Zin = 1'b1; ALU_op = ALU_ADD; end
`endif
                    default: ;
                endcase
            end
            S_T6: begin
                case (iclass)
                    CL_MUL:   begin Zhiout = 1'b1; HIin = 1'b1; end
`ifdef CU_BRANCH_EN
                    CL_BR:    begin Zlowout = 1'b1; PCin = CON_FF; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifndef CU_BRANCH_EN
    logic unused_con;
    assign unused_con = CON_FF;
`endif

    // No store instructions are sequenced here.
    assign Write = 1'b0;
    assign BAout = 1'b0;

    assign Run           = (state_q != S_RST) && (state_q != S_HALT);
    assign Present_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instructions, random
// instruction stream, Stop/halt/abort cases, checked against a table model.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        Stop = 1'b0;
    logic        CON_FF = 1'b0;

    logic PCout, Zlowout, Zhiout, MDRout, HIout, LOout, InPortout, Cout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Out_Portin, CONin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] ALU_op;
    logic       Run;
    logic [3:0] Present_state;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] ST_HALT = 4'hE;
    localparam logic [3:0] ST_RST  = 4'hF;

    typedef struct packed {
        logic PCout, Zlowout, Zhiout, MDRout, HIout, LOout, InPortout, Cout;
        logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Out_Portin, CONin;
        logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    } strb_t;

    strb_t obs;
    assign obs = {PCout, Zlowout, Zhiout, MDRout, HIout, LOout, InPortout, Cout,
                  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Out_Portin, CONin,
                  IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop), .CON_FF(CON_FF),
        .PCout(PCout), .Zlowout(Zlowout), .Zhiout(Zhiout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .Out_Portin(Out_Portin),
        .CONin(CONin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .ALU_op(ALU_op), .Run(Run), .Present_state(Present_state)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef CU_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    // Reference model: what each opcode does at each T-step.
    function automatic bit is_rtype(input logic [4:0] opc);
        return opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
    endfunction

    function automatic bit is_br(input logic [4:0] opc);
        return BR_EN && (opc == 5'b10010);
    endfunction

    function automatic int exec_len(input logic [4:0] opc);
        if (is_rtype(opc) || opc == 5'b01100) return 3;
        if (opc == 5'b01111 || is_br(opc))   return 4;
        return 1;
    endfunction

    function automatic strb_t exp_strb(input logic [4:0] opc, input int step, input logic con);
        strb_t s = '0;
        case (step)
            0: begin s.PCout = 1; s.MARin = 1; s.IncPC = 1; s.Zin = 1; end
            1: begin s.Zlowout = 1; s.PCin = 1; s.Read = 1; s.MDRin = 1; end
            2: begin s.MDRout = 1; s.IRin = 1; end
            3: begin
                if (is_rtype(opc) || opc == 5'b01100) begin s.Grb = 1; s.Rout = 1; s.Yin = 1; end
                else if (opc == 5'b01111) begin s.Gra = 1; s.Rout = 1; s.Yin = 1; end
                else if (opc == 5'b11000) begin s.HIout = 1; s.Gra = 1; s.Rin = 1; end
                else if (opc == 5'b11001) begin s.LOout = 1; s.Gra = 1; s.Rin = 1; end
                else if (opc == 5'b10110) begin s.InPortout = 1; s.Gra = 1; s.Rin = 1; end
                else if (opc == 5'b10111) begin s.Gra = 1; s.Rout = 1; s.Out_Portin = 1; end
                else if (is_br(opc)) begin s.Gra = 1; s.Rout = 1; s.CONin = 1; end
            end
            4: begin
                if (is_rtype(opc)) begin s.Grc = 1; s.Rout = 1; s.Zin = 1; end
                else if (opc == 5'b01100) begin s.Cout = 1; s.Zin = 1; end
                else if (opc == 5'b01111) begin s.Grb = 1; s.Rout = 1; s.Zin = 1; end
                else if (is_br(opc)) begin s.PCout = 1; s.Yin = 1; end
            end
            5: begin
                if (is_rtype(opc) || opc == 5'b01100) begin s.Zlowout = 1; s.Gra = 1; s.Rin = 1; end
                else if (opc == 5'b01111) begin s.Zlowout = 1; s.LOin = 1; end
                else if (is_br(opc)) begin s.Cout = 1; s.Zin = 1; end
            end
            6: begin
                if (opc == 5'b01111) begin s.Zhiout = 1; s.HIin = 1; end
                else if (is_br(opc)) begin s.Zlowout = 1; s.PCin = con; end
            end
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic [4:0] exp_alu(input logic [4:0] opc, input int step);
        if (step == 4 && is_rtype(opc))     return opc;
        if (step == 4 && opc == 5'b01100)   return 5'b00011;
        if (step == 4 && opc == 5'b01111)   return 5'b01111;
        if (step == 5 && is_br(opc))        return 5'b00011;
        return 5'b00000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] st);
        chk({tag, "_state"}, {28'h0, Present_state}, {28'h0, st});
        chk({tag, "_strobes"}, {5'h0, obs}, 32'h0);
        chk({tag, "_alu"}, {27'h0, ALU_op}, 32'h0);
        chk({tag, "_run"}, {31'h0, Run}, 32'h0);
    endtask

    task automatic do_reset();
        Clear = 1'b0;
        Stop  = 1'b0;
        repeat (2) begin
            @(posedge Clock); #1;
            chk_idle("reset", ST_RST);
        end
        Clear = 1'b1;
        @(posedge Clock); #1;
    endtask

    // Walk one instruction from T0; stop_step < 0 means Stop never raised.
    task automatic run_instr(input logic [31:0] ir, input logic con,
                             input int stop_step, input string tag);
        logic [4:0] opc;
        int total;
        bit halt_exp;
        int nbus;
        opc    = ir[31:27];
        total  = 3 + exec_len(opc);
        IR     = ir;
        CON_FF = con;
        for (int s = 0; s < total; s++) begin
            chk($sformatf("%s_T%0d_state", tag, s), {28'h0, Present_state}, s);
            chk($sformatf("%s_T%0d_strobes", tag, s), {5'h0, obs}, {5'h0, exp_strb(opc, s, con)});
            chk($sformatf("%s_T%0d_alu", tag, s), {27'h0, ALU_op}, {27'h0, exp_alu(opc, s)});
            chk($sformatf("%s_T%0d_run", tag, s), {31'h0, Run}, 32'h1);
            chk($sformatf("%s_T%0d_rin_rout", tag, s), {31'h0, Rin & Rout}, 32'h0);
            nbus = $countones({PCout, Zlowout, Zhiout, MDRout, HIout, LOout,
                               InPortout, Cout, Rout, BAout});
            chk($sformatf("%s_T%0d_bus_drivers_gt1", tag, s), {31'h0, nbus > 1}, 32'h0);
            if (s == stop_step) Stop = 1'b1;
            @(posedge Clock); #1;
        end
        halt_exp = (opc == 5'b11011) || (stop_step >= 0 && stop_step < total);
        Stop = 1'b0;
        chk($sformatf("%s_next_state", tag), {28'h0, Present_state},
            halt_exp ? {28'h0, ST_HALT} : 32'h0);
    endtask

    task automatic hold_halt(input string tag);
        for (int i = 0; i < 10; i++) begin
            Stop = (i % 3 == 0);
            @(posedge Clock); #1;
            chk_idle(tag, ST_HALT);
        end
        Stop = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  opc;

        do_reset();
        run_instr(32'h18918000, 1'b0, -1, "add");
        run_instr(32'h79880000, 1'b0, -1, "mul");
        run_instr(32'hC9000000, 1'b0, -1, "mflo");
        run_instr(32'h90000000, 1'b1, -1, "br_con1");
        run_instr(32'h90000000, 1'b0, -1, "br_con0");

        for (int n = 0; n < 40; n++) begin
            r   = $urandom();
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'b11011) opc = 5'b11010;
            r[31:27] = opc;
            run_instr(r, 1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", n));
        end

        // Clear dropped mid-mul must kill every strobe immediately.
        IR = 32'h79880000;
        repeat (4) @(posedge Clock);
        #1;
        chk("abort_pre_state", {28'h0, Present_state}, 32'h4);
        #2 Clear = 1'b0;
        #1;
        chk_idle("abort", ST_RST);
        do_reset();

        // Stop raised at T4 of add: T5 still writes back, then HALT.
        run_instr(32'h18918000, 1'b0, 4, "add_stop");
        hold_halt("stop_halt");
        do_reset();

        run_instr(32'hD8000000, 1'b0, -1, "halt");
        hold_halt("halt_hold");
        do_reset();

        run_instr(32'h21118000, 1'b0, -1, "sub_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the Datapath strobe inputs (PCout, MARin, Zin, Gra/Grb/Grc, Rin/Rout, ...).
- Replaces the hand-sequenced fetch/execute stimulus with a clocked T-state machine.
- Reads the opcode from the Datapath IR output and walks each instruction through fetch (T0–T2) and execute (T3–T6).
- Sits directly upstream of the Datapath; its outputs connect 1:1 to the Datapath control inputs.

Parameters:
- OPC_W, 5, opcode width; opcode = IR[31:27].
- ALU_OP_W, 5, width of the ALU_op output.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  asynchronous, active-low reset.
- IR  in  32  Datapath IR register output.
- Stop  in  1  request halt at the next instruction boundary.
- CON_FF  in  1  branch-condition flag from the Datapath.
- PCout, Zlowout, Zhiout, MDRout, HIout, LOout, InPortout, Cout  out  1 each  bus-drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Out_Portin, CONin  out  1 each  register-load strobes.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes.
- ALU_op  out  ALU_OP_W  ALU operation code, valid while Zin=1.
- Run  out  1  1 while executing, 0 in RST and HALT.
- Present_state  out  4  current state, for debug.

Behaviour:
- States: RST, T0..T6, HALT.
- While Clear=0: state=RST, all strobes 0, ALU_op=0, Run=0.
- First rising edge after Clear=1: RST->T0, Run=1.
- Clear=0 mid-instruction aborts immediately; no partial strobe survives.
- Strobes are a combinational (Moore) decode of state plus latched IR. Each state lasts exactly one clock; the Datapath samples at the next rising edge.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - IR is valid from T3 on.
- Execute, by opcode:
  - add 00011 / sub 00100 / and 00101 / or 00110: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,ALU_op=opcode; T5 Zlowout,Gra,Rin. 6 cycles total.
  - addi 01100: T3 Grb,Rout,Yin; T4 Cout,Zin,ALU_op=00011; T5 Zlowout,Gra,Rin.
  - mul 01111: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin,ALU_op=01111; T5 Zlowout,LOin; T6 Zhiout,HIin. 7 cycles total.
  - mfhi 11000: T3 HIout,Gra,Rin. mflo 11001: T3 LOout,Gra,Rin.
  - in 10110: T3 InPortout,Gra,Rin. out 10111: T3 Gra,Rout,Out_Portin.
  - nop 11010 and any unlisted opcode: T3 with no strobes asserted.
  - halt 11011: T3 -> HALT.
- The last execute state of each instruction transitions to T0.
- HALT: all strobes 0, Run=0. Exit only via Clear.
- Stop:
  - Sampled on the edge leaving an instruction's last state.
  - If Stop=1, go to HALT instead of T0.
  - Stop asserted mid-instruction never truncates the instruction.
- Never assert together: Rin and Rout; more than one bus driver in the same state.
- Write and BAout are held 0 (no memory-store instructions in this block).

Optional Feature:
- Macro: CU_BRANCH_EN.
- Defined: opcode 10010 (br) is decoded as:
  - T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin,ALU_op=00011.
  - T6 Zlowout, plus PCin only if CON_FF=1.
  - Then T0.
- Undefined: CONin is held 0, CON_FF is ignored, and 10010 executes as nop.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams;
  - state encodings (RST=4'hF, HALT=4'hE, T0..T6=0..6);
  - ALU_op codes.
- One sub-module, cu_decode: combinational opcode -> instruction class (RTYPE, ADDI, MUL, MFHI, MFLO, IN, OUT, BR, NOP, HALT).
- The sequencer FSM and strobe decode stay in control_sequencer.

Test Plan:
- Reset: Clear=0 for 2 cycles -> all strobes 0, Run=0, state=RST. Release Clear -> next edge state=T0 with PCout=MARin=IncPC=Zin=1.
- add R1,R2,R3 (IR=0x18918000): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,ALU_op=00011; T5 Zlowout,Gra,Rin; then T0. Instruction spans 6 clocks.
- mul R3,R1 (IR=0x79880000): T5 LOin=1 and T6 HIin=1; back to T0 after 7 clocks.
- mflo R2 (IR=0xC9000000): T3 LOout=Gra=Rin=1, all else 0; then T0.
- halt (IR=0xD8000000), and Stop=1 during an add at T4: both -> HALT, Run=0. Add's T5 still issues Rin. Held in HALT for 10 cycles until Clear.
- CU_BRANCH_EN, br with CON_FF=1 vs 0: PCin=1 in T6 vs PCin=0 in T6. Without the macro, the same IR passes through T3 with no strobes.
